// File: rtl/cpu_pkg.sv
// Shared types for the RV32 integer datapath control: ALU operations,
// handled opcodes, multi-cycle sequencer states and funct7 constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [6:0] {
    ALU_WITH_TWO_REGISTERS = 7'b0110011,
    ALU_WITH_IMMEDIATE     = 7'b0010011
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } mc_state_t;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // funct3 mapping common to register and immediate forms; SLT and SLTU share one op
  function automatic alu_op_t funct3_to_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control decoder for R-type and I-type ALU instructions.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    alu_op,
  output logic       use_imm,
  output logic       legal
);

  always_comb begin
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    legal   = 1'b0;
    case (opcode)
      ALU_WITH_TWO_REGISTERS: begin
        legal  = 1'b1;
        alu_op = funct3_to_op(funct3);
        // only the ADD/SUB slot inspects funct7
        if (funct3 == 3'b000) begin
          if (funct7 == F7_SUB) alu_op = ALU_SUB;
          else if (funct7 != F7_ADD) legal = 1'b0;
        end
      end
      ALU_WITH_IMMEDIATE: begin
        legal   = 1'b1;
        use_imm = 1'b1;
        alu_op  = funct3_to_op(funct3);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: fetch over req/ack, decode, execute,
// writeback; halts permanently on an illegal encoding.
module mc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic [2:0]          alu_op,
  output logic                use_imm,
  output logic                reg_write,
  output logic                pc_write,
  output logic                halted,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired_count,
  output logic [2:0]          state_out
);

  mc_state_t           state, state_nx;
  logic [31:0]         ir;
  alu_op_t             alu_op_q;
  logic                use_imm_q;
  logic                illegal_q;
  logic [RETIRE_W-1:0] retired_q;

  alu_op_t dec_op;
  logic    dec_imm;
  logic    dec_legal;

  alu_decoder u_alu_decoder (
    .opcode  (ir[6:0]),
    .funct3  (ir[14:12]),
    .funct7  (ir[31:25]),
    .alu_op  (dec_op),
    .use_imm (dec_imm),
    .legal   (dec_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // strobes depend on state only, so asserting reset drops them at once
  always_comb begin
    state_nx  = state;
    imem_req  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    case (state)
      ST_IDLE:      if (start) state_nx = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nx = ST_DECODE;
      end
      ST_DECODE:    state_nx = dec_legal ? ST_EXECUTE : ST_HALT;
      ST_EXECUTE:   state_nx = ST_WRITEBACK;
      ST_WRITEBACK: begin
        reg_write = (ir[11:7] != 5'd0);
        pc_write  = 1'b1;
        state_nx  = ST_FETCH;
      end
      ST_HALT:      state_nx = ST_HALT;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir        <= '0;
      alu_op_q  <= ALU_ADD;
      use_imm_q <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state == ST_FETCH && imem_ack) ir <= imem_rdata;
      if (state == ST_DECODE) begin
        alu_op_q  <= dec_op;
        use_imm_q <= dec_imm;
        if (!dec_legal) illegal_q <= 1'b1;
      end
      if (state == ST_WRITEBACK) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  assign instr         = ir;
  assign alu_op        = alu_op_q;
  assign use_imm       = use_imm_q;
  assign halted        = (state == ST_HALT);
  assign illegal       = illegal_q;
  assign retired_count = retired_q;
  assign state_out     = state;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: a default-width instance and a 2-bit
// retire-counter instance share all stimulus.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, reg_write, pc_write, use_imm, halted, illegal;
  logic [31:0] instr;
  logic [2:0]  alu_op, state_out;
  logic [31:0] retired_count;

  logic        w2_imem_req, w2_reg_write, w2_pc_write, w2_use_imm, w2_halted, w2_illegal;
  logic [31:0] w2_instr;
  logic [2:0]  w2_alu_op, w2_state_out;
  logic [1:0]  w2_retired_count;

  int          checks   = 0;
  int          failures = 0;
  int unsigned exp_ret  = 0;

  always #5 clk = ~clk;

  mc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .alu_op(alu_op),
    .use_imm(use_imm), .reg_write(reg_write), .pc_write(pc_write), .halted(halted),
    .illegal(illegal), .retired_count(retired_count), .state_out(state_out)
  );

  mc_sequencer #(.RETIRE_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .start(start), .imem_req(w2_imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(w2_instr), .alu_op(w2_alu_op),
    .use_imm(w2_use_imm), .reg_write(w2_reg_write), .pc_write(w2_pc_write),
    .halted(w2_halted), .illegal(w2_illegal), .retired_count(w2_retired_count),
    .state_out(w2_state_out)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0;
    tick; tick;
    reset = 1'b0;
    exp_ret = 0;
  endtask

  task automatic start_fetch;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // from FETCH with zero-wait ack; returns in the following FETCH
  task automatic feed(input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word;
    tick;
    imem_ack = 1'b0;
    tick; tick; tick;
    exp_ret++;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    tick; tick;
    checks++;
    if ({state_out, imem_req, reg_write, pc_write} !== {3'd0, 3'b000}) begin
      failures++; $display("FAIL reset_state got=%b exp=%b", {state_out, imem_req, reg_write, pc_write}, 6'b000000);
    end
    checks++;
    if ({instr, alu_op, use_imm, halted, illegal} !== {32'h0, 3'd0, 3'b000}) begin
      failures++; $display("FAIL reset_regs got=%h exp=%h", {instr, alu_op, use_imm, halted, illegal}, 38'h0);
    end
    checks++;
    if (retired_count !== 32'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", retired_count);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (state_out !== 3'd0) begin
      failures++; $display("FAIL idle_no_start got=%0d exp=0", state_out);
    end
    exp_ret = 0;
  endtask

  task automatic test_addi;
    start = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick;
    start = 1'b0;
    checks++;
    if ({state_out, imem_req} !== {3'd1, 1'b1}) begin
      failures++; $display("FAIL addi_fetch got=%b exp=%b", {state_out, imem_req}, 4'b0011);
    end
    tick;
    checks++;
    if ({state_out, imem_req} !== {3'd2, 1'b0} || instr !== 32'h0050_0093) begin
      failures++; $display("FAIL addi_decode state=%0d req=%b ir=%h exp state=2 req=0 ir=00500093", state_out, imem_req, instr);
    end
    imem_rdata = 32'hFFFF_FFFF;  // ack held outside FETCH
    tick;
    checks++;
    if ({state_out, alu_op, use_imm, reg_write, pc_write} !== {3'd3, 3'd0, 1'b1, 2'b00}) begin
      failures++; $display("FAIL addi_execute got=%b exp=%b", {state_out, alu_op, use_imm, reg_write, pc_write}, 9'b011000100);
    end
    checks++;
    if (instr !== 32'h0050_0093) begin
      failures++; $display("FAIL ack_outside_fetch got=%h exp=00500093", instr);
    end
    imem_ack = 1'b0;
    tick;
    checks++;
    if ({state_out, reg_write, pc_write} !== {3'd4, 2'b11} || retired_count !== 32'd0) begin
      failures++; $display("FAIL addi_writeback state=%0d rw=%b pw=%b cnt=%0d exp 4 1 1 0", state_out, reg_write, pc_write, retired_count);
    end
    tick;
    exp_ret = 1;
    checks++;
    if ({state_out, reg_write, pc_write} !== {3'd1, 2'b00} || retired_count !== exp_ret) begin
      failures++; $display("FAIL addi_retire state=%0d rw=%b pw=%b cnt=%0d exp 1 0 0 %0d", state_out, reg_write, pc_write, retired_count, exp_ret);
    end
    checks++;
    if (w2_retired_count !== exp_ret[1:0] || instr !== 32'h0050_0093) begin
      failures++; $display("FAIL addi_w2_and_ir cnt=%0d ir=%h exp %0d 00500093", w2_retired_count, instr, exp_ret[1:0]);
    end
  endtask

  task automatic test_back_to_back;
    feed(32'h0020_81B3);
    checks++;
    if ({alu_op, use_imm} !== {3'd0, 1'b0} || retired_count !== exp_ret) begin
      failures++; $display("FAIL b2b_add op=%0d imm=%b cnt=%0d exp 0 0 %0d", alu_op, use_imm, retired_count, exp_ret);
    end
    feed(32'h4020_81B3);
    checks++;
    if ({alu_op, use_imm} !== {3'd1, 1'b0} || retired_count !== exp_ret || state_out !== 3'd1) begin
      failures++; $display("FAIL b2b_sub op=%0d imm=%b cnt=%0d st=%0d exp 1 0 %0d 1", alu_op, use_imm, retired_count, state_out, exp_ret);
    end
    checks++;
    if ({halted, illegal} !== 2'b00) begin
      failures++; $display("FAIL b2b_no_halt got=%b exp=00", {halted, illegal});
    end
  endtask

  task automatic test_decode_table;
    logic [31:0] words [6] = '{32'h0020_C1B3, 32'h0030_9093, 32'h0020_B1B3,
                               32'h0FF0_F213, 32'h4020_D093, 32'h0020_E1B3};
    logic [3:0]  exp   [6] = '{{3'd4, 1'b0}, {3'd5, 1'b1}, {3'd7, 1'b0},
                               {3'd2, 1'b1}, {3'd6, 1'b1}, {3'd3, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      feed(words[i]);
      checks++;
      if ({alu_op, use_imm} !== exp[i] || state_out !== 3'd1) begin
        failures++; $display("FAIL decode_%0d word=%h op_imm=%b st=%0d exp %b 1", i, words[i], {alu_op, use_imm}, state_out, exp[i]);
      end
    end
    checks++;
    if (retired_count !== exp_ret) begin
      failures++; $display("FAIL decode_count got=%0d exp=%0d", retired_count, exp_ret);
    end
  endtask

  task automatic test_delayed_ack;
    logic [31:0] old_ir;
    int unsigned req_cycles;
    old_ir = instr;
    req_cycles = 0;
    imem_ack = 1'b0; imem_rdata = 32'h0020_C1B3;
    for (int i = 0; i < 3; i++) begin
      if (imem_req === 1'b1) req_cycles++;
      checks++;
      if (instr !== old_ir || state_out !== 3'd1) begin
        failures++; $display("FAIL wait_%0d ir=%h st=%0d exp %h 1", i, instr, state_out, old_ir);
      end
      tick;
    end
    if (imem_req === 1'b1) req_cycles++;
    imem_ack = 1'b1;
    tick;
    imem_ack = 1'b0;
    checks++;
    if (req_cycles != 4 || instr !== 32'h0020_C1B3) begin
      failures++; $display("FAIL wait_req req_cycles=%0d ir=%h exp 4 0020c1b3", req_cycles, instr);
    end
    tick; tick;
    checks++;
    if (retired_count !== exp_ret || state_out !== 3'd4) begin
      failures++; $display("FAIL wait_wb cnt=%0d st=%0d exp %0d 4", retired_count, state_out, exp_ret);
    end
    tick;
    exp_ret++;
    checks++;
    if (retired_count !== exp_ret || alu_op !== 3'd4) begin
      failures++; $display("FAIL wait_retire cnt=%0d op=%0d exp %0d 4", retired_count, alu_op, exp_ret);
    end
  endtask

  task automatic test_x0_write;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick;
    imem_ack = 1'b0;
    tick; tick;
    checks++;
    if ({state_out, reg_write, pc_write} !== {3'd4, 2'b01}) begin
      failures++; $display("FAIL x0_wb got=%b exp=%b", {state_out, reg_write, pc_write}, 5'b10001);
    end
    tick;
    exp_ret++;
    checks++;
    if (retired_count !== exp_ret) begin
      failures++; $display("FAIL x0_count got=%0d exp=%0d", retired_count, exp_ret);
    end
  endtask

  task automatic test_illegal(input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word;
    tick;
    imem_ack = 1'b0;
    checks++;
    if (state_out !== 3'd2 || illegal !== 1'b0) begin
      failures++; $display("FAIL illegal_decode_%h st=%0d ill=%b exp 2 0", word, state_out, illegal);
    end
    tick;
    checks++;
    if ({state_out, halted, illegal, imem_req, reg_write, pc_write} !== {3'd5, 5'b11000}) begin
      failures++; $display("FAIL illegal_halt_%h got=%b exp=%b", word, {state_out, halted, illegal, imem_req, reg_write, pc_write}, 8'b10111000);
    end
    start = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    repeat (3) tick;
    start = 1'b0; imem_ack = 1'b0;
    checks++;
    if ({state_out, halted, illegal, imem_req, reg_write, pc_write} !== {3'd5, 5'b11000} ||
        instr !== word || retired_count !== exp_ret) begin
      failures++; $display("FAIL illegal_absorb_%h st=%0d ir=%h cnt=%0d exp 5 %h %0d", word, state_out, instr, retired_count, word, exp_ret);
    end
  endtask

  task automatic test_reset_mid_fetch;
    apply_reset;
    checks++;
    if ({state_out, halted, illegal} !== {3'd0, 2'b00}) begin
      failures++; $display("FAIL reset_clears_halt got=%b exp=00000", {state_out, halted, illegal});
    end
    start_fetch;
    feed(32'h0050_0093);
    imem_ack = 1'b1; imem_rdata = 32'h0020_C1B3;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state_out, imem_req} !== 4'b0000 || instr !== 32'h0 || retired_count !== 32'd0 ||
        {alu_op, use_imm} !== 4'b0000) begin
      failures++; $display("FAIL reset_mid_fetch st=%0d req=%b ir=%h cnt=%0d op=%0d imm=%b exp all 0", state_out, imem_req, instr, retired_count, alu_op, use_imm);
    end
    tick;
    reset = 1'b0; imem_ack = 1'b0;
    exp_ret = 0;
    checks++;
    if (instr !== 32'h0 || state_out !== 3'd0) begin
      failures++; $display("FAIL reset_discard_ack ir=%h st=%0d exp 0 0", instr, state_out);
    end
    start_fetch;
    checks++;
    if ({state_out, imem_req} !== {3'd1, 1'b1}) begin
      failures++; $display("FAIL restart_fetch got=%b exp=0011", {state_out, imem_req});
    end
  endtask

  task automatic test_wrap_and_reset_wb;
    repeat (4) feed(32'h0050_0093);
    checks++;
    if (retired_count !== 32'd4 || w2_retired_count !== 2'd0) begin
      failures++; $display("FAIL wrap cnt=%0d w2=%0d exp 4 0", retired_count, w2_retired_count);
    end
    repeat (3) feed(32'h0050_0093);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick;
    imem_ack = 1'b0;
    tick; tick;
    checks++;
    if ({w2_state_out, w2_reg_write, w2_pc_write} !== {3'd4, 2'b11} || w2_retired_count !== 2'd3) begin
      failures++; $display("FAIL w2_pre_reset st=%0d rw=%b pw=%b cnt=%0d exp 4 1 1 3", w2_state_out, w2_reg_write, w2_pc_write, w2_retired_count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({w2_state_out, w2_reg_write, w2_pc_write, w2_imem_req, w2_retired_count} !== 8'h00 ||
        {reg_write, pc_write, retired_count} !== 34'h0) begin
      failures++; $display("FAIL reset_mid_wb w2st=%0d rw=%b pw=%b w2cnt=%0d cnt=%0d exp all 0", w2_state_out, w2_reg_write, w2_pc_write, w2_retired_count, retired_count);
    end
    tick;
    reset = 1'b0;
    exp_ret = 0;
    tick;
    start_fetch;
    checks++;
    if ({w2_state_out, w2_imem_req} !== {3'd1, 1'b1}) begin
      failures++; $display("FAIL w2_restart got=%b exp=0011", {w2_state_out, w2_imem_req});
    end
    feed(32'h0050_0093);
    checks++;
    if (w2_retired_count !== 2'd1 || retired_count !== exp_ret) begin
      failures++; $display("FAIL after_reset_count w2=%0d cnt=%0d exp 1 %0d", w2_retired_count, retired_count, exp_ret);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    test_reset;
    test_addi;
    test_back_to_back;
    test_decode_table;
    test_delayed_ack;
    test_x0_write;
    test_illegal(32'h0000_0003);
    apply_reset;
    start_fetch;
    test_illegal(32'h2020_81B3);
    test_reset_mid_fetch;
    test_wrap_and_reset_wb;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
